irb_pingpong_buf: RTL
=====================

# irb_pingpong_buf

Parametrised multi-bank tile buffer between the DMA (producer) and a convolution engine (consumer) of the inverted residual block. It lets the DMA fill tile N+1 while the engine reads tile N, replacing the single-bank RAM_FMI/RAM_FMINT scheme with its write-selects-address muxing. Banks form a ring with a full/empty handshake and a per-tile committed length. It is one instance per buffered feature map.

## Interface
- DATA_W, 16 (PX_W): word width
- DEPTH, 256: words per bank, ≥2, need not be a power of two
- NBANK, 2: number of banks, 2..4
- AW, $clog2(DEPTH): address width, derived
- LW, $clog2(DEPTH+1): length width, derived
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all pointers, level and err
- wr_en  in  1  write wr_data into the current write bank
- wr_addr  in  AW  word address inside the bank
- wr_data  in  DATA_W  write data
- wr_commit  in  1  close the current write bank as a full tile
- wr_len  in  LW  valid words in the committed tile
- wr_ready  out  1  a free bank exists (level < NBANK)
- rd_en  in  1  read request
- rd_addr  in  AW  word address inside the current read bank
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data holds the result of last cycle's accepted read
- rd_avail  out  1  a full bank exists (level > 0)
- rd_len  out  LW  committed length of the current read bank, 0 when !rd_avail
- rd_release  in  1  consumer done with the current read bank
- level  out  $clog2(NBANK+1)  number of full banks
- err  out  1  sticky protocol error

## Operation
- State: wr_ptr and rd_ptr (0..NBANK-1, wrap NBANK-1→0), level, len[NBANK], err.
- Physical address = bank*DEPTH + addr.
- Write is accepted when wr_en & wr_ready & wr_addr<DEPTH. Otherwise it is dropped and err is set.
- Commit is accepted when wr_ready: len[wr_ptr]←wr_len, wr_ptr advances, level+1. When !wr_ready the commit is dropped and err is set. wr_len>DEPTH is saturated to DEPTH and err is set.
- A write and a commit in the same cycle: the write lands in the bank being committed (pre-advance pointer).
- Read is accepted when rd_en & rd_avail & rd_addr<DEPTH. Otherwise rd_valid stays 0 next cycle, rd_data holds its value, and err is set.
- Release is accepted when rd_avail: rd_ptr advances, level-1. When !rd_avail it is ignored and err is set.
- A read and a release in the same cycle: the read uses the pre-release bank.
- A commit and a release in the same cycle: both pointers advance and level is unchanged.
- The write bank never equals the read bank while both are active, because write is blocked when full and read is blocked when empty.
- flush has priority over all inputs: pointers, level and err go to 0, rd_valid goes to 0 next cycle, and len and RAM contents are kept.
- err clears only on rst or flush.

## Timing
- Reset values: rd_data 0, rd_valid 0, err 0, level 0, rd_len 0, wr_ready 1, rd_avail 0. Pointers are 0. RAM contents are not reset.
- Read latency: 1 cycle, rd_data/rd_valid registered.
- wr_ready, rd_avail, rd_len and level are combinational from registered state. They update the cycle after a commit, release or flush.
- Data written in cycle t together with a commit in cycle t is readable from cycle t+1.
- Full throughput: one write and one read per cycle, with no bubbles at a bank swap.
- rst asserted mid-transfer: immediate clear. Tiles in flight are lost and the producer must restart.

## Structure
- irb_pkg: add the BUF_DEPTH_FMI/BUF_DEPTH_FMINT and BUF_NBANK constants used at instantiation. DATA_W defaults from PX_W.
- Sub-module irb_sdp_ram: simple dual-port RAM with NBANK*DEPTH words, 1 write and 1 registered read port, no reset on the array, inferable as block RAM.
- Pointer, level and len bookkeeping plus error logic live in irb_pingpong_buf.

## Test plan
All scenarios use DATA_W=16, DEPTH=8, NBANK=2.
- Reset, then fill bank 0 with addresses 0..7 = 0x100..0x107 and commit with len 8 -> level 1, rd_avail 1, rd_len 8. Reading addresses 0..7 returns 0x100..0x107, one cycle after each rd_en.
- Overlap: fill bank 1 (0x200..) while reading bank 0, then release bank 0 and commit bank 1 in the same cycle -> level stays 1, rd_len switches to bank 1's len, and the next read of address 3 returns 0x203.
- Full: commit 2 tiles, then issue wr_en and wr_commit -> wr_ready 0, both dropped, err 1, level 2, and bank 0 data intact.
- Empty: rd_en and rd_release with level 0 -> rd_valid stays 0, err 1, level 0.
- Partial tile: commit with wr_len 5, then wr_len 9 -> rd_len 5 for the first tile, rd_len 8 for the second, err 1.
- Wrap and flush: run 5 commit/release cycles -> pointers wrap and data stays correct. Assert flush with level 2 -> level 0, err 0, rd_valid 0. Assert rst low mid-write -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/irb_pingpong_buf_pkg.sv
// ---------------------------------------------------------------------------
// irb_pingpong_buf_pkg
// Shared constants for the inverted-residual-block tile buffers.
//   PX_W             pixel word width; the default buffer word width
//   BUF_DEPTH_FMI    words per bank of the input feature-map buffer
//   BUF_DEPTH_FMINT  words per bank of the intermediate feature-map buffer
//   BUF_NBANK        number of banks in every ring
//   clog2_min1()     $clog2 clamped to at least one bit, for index widths
// ---------------------------------------------------------------------------
package irb_pingpong_buf_pkg;

    localparam int PX_W            = 16;
    localparam int BUF_DEPTH_FMI   = 256;
    localparam int BUF_DEPTH_FMINT = 384;
    localparam int BUF_NBANK       = 2;

    // A one-entry range still needs a one-bit index signal.
    function automatic int clog2_min1(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/irb_pingpong_buf_if.sv
// ---------------------------------------------------------------------------
// irb_pingpong_buf_if
// Producer/consumer bundle of the ping-pong tile buffer.
//   master : DMA write side and engine read side (drives requests)
//   slave  : the buffer itself (drives status and read data)
// Write side : wr_en, wr_addr, wr_data, wr_commit, wr_len -> wr_ready
// Read side  : rd_en, rd_addr, rd_release -> rd_data, rd_valid, rd_avail,
//              rd_len
// Status     : level (full banks), err (sticky protocol error)
// ---------------------------------------------------------------------------
interface irb_pingpong_buf_if
    import irb_pingpong_buf_pkg::*;
#(
    parameter int DATA_W = PX_W,
    parameter int DEPTH  = BUF_DEPTH_FMI,
    parameter int NBANK  = BUF_NBANK
) ();

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = $clog2(DEPTH + 1);
    localparam int LVW = $clog2(NBANK + 1);

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit;
    logic [LW-1:0]     wr_len;
    logic              wr_ready;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_avail;
    logic [LW-1:0]     rd_len;
    logic              rd_release;
    logic [LVW-1:0]    level;
    logic              err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit, wr_len,
        output rd_en, rd_addr, rd_release,
        input  wr_ready, rd_data, rd_valid, rd_avail, rd_len, level, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit, wr_len,
        input  rd_en, rd_addr, rd_release,
        output wr_ready, rd_data, rd_valid, rd_avail, rd_len, level, err
    );

endinterface

// File: rtl/irb_pingpong_buf_sdp_ram.sv
// ---------------------------------------------------------------------------
// irb_sdp_ram
// Simple dual-port RAM: one write port, one registered read port.
// The array itself has no reset so it maps onto block RAM; only the output
// register is cleared, and it holds its value on cycles without a read.
//   clk, rst      clock, asynchronous active-low reset of the output reg
//   we/waddr/wdata write port
//   re/raddr       read request; rdata valid the following cycle
// ---------------------------------------------------------------------------
module irb_sdp_ram
    import irb_pingpong_buf_pkg::*;
#(
    parameter int DATA_W = PX_W,
    parameter int WORDS  = 2 * BUF_DEPTH_FMI,
    localparam int RAW   = clog2_min1(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RAW-1:0]    waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [RAW-1:0]    raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [WORDS];

    // Write port into the storage array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its last value when no read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/irb_pingpong_buf.sv
// ---------------------------------------------------------------------------
// irb_pingpong_buf
// NBANK-bank ring of tile buffers between the DMA and a convolution engine.
// The producer fills the bank at wr_ptr and closes it with wr_commit; the
// consumer reads the bank at rd_ptr and frees it with rd_release. level
// counts full banks, so the two pointers never meet on an active bank.
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   flush  synchronous clear of pointers, level, err and rd_valid
//   bus    irb_pingpong_buf_if.slave: write/read handshakes and status
// ---------------------------------------------------------------------------
module irb_pingpong_buf
    import irb_pingpong_buf_pkg::*;
#(
    parameter int DATA_W = PX_W,
    parameter int DEPTH  = BUF_DEPTH_FMI,
    parameter int NBANK  = BUF_NBANK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    irb_pingpong_buf_if.slave bus
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = $clog2(DEPTH + 1);
    localparam int LVW = $clog2(NBANK + 1);
    localparam int PW  = clog2_min1(NBANK);
    localparam int RAW = clog2_min1(NBANK * DEPTH);

    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [LVW-1:0]    level_r;
    logic [LVW-1:0]    level_nxt_s;
    logic [LW-1:0]     len_r [NBANK];
    logic [LW-1:0]     len_sat_s;
    logic              len_over_s;
    logic              err_r;
    logic              err_set_s;
    logic              rd_valid_r;
    logic              wr_ready_s;
    logic              rd_avail_s;
    logic              wr_addr_ok_s;
    logic              rd_addr_ok_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              commit_acc_s;
    logic              release_acc_s;
    logic [RAW-1:0]    wr_phys_s;
    logic [RAW-1:0]    rd_phys_s;
    logic [DATA_W-1:0] rd_data_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(NBANK - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // A power-of-two depth makes every address in range by construction.
    generate
        if (DEPTH == (1 << AW)) begin : g_addr_pow2
            assign wr_addr_ok_s = 1'b1;
            assign rd_addr_ok_s = 1'b1;
        end else begin : g_addr_range
            assign wr_addr_ok_s = (LW'(bus.wr_addr) < LW'(DEPTH));
            assign rd_addr_ok_s = (LW'(bus.rd_addr) < LW'(DEPTH));
        end
    endgenerate

    assign wr_ready_s = (level_r < LVW'(NBANK));
    assign rd_avail_s = (level_r != {LVW{1'b0}});

    // flush overrides every request in its cycle.
    assign wr_acc_s      = bus.wr_en & wr_ready_s & wr_addr_ok_s & ~flush;
    assign rd_acc_s      = bus.rd_en & rd_avail_s & rd_addr_ok_s & ~flush;
    assign commit_acc_s  = bus.wr_commit & wr_ready_s & ~flush;
    assign release_acc_s = bus.rd_release & rd_avail_s & ~flush;

    // Both ports use the pre-advance pointers, so a write with a commit lands
    // in the tile being closed and a read with a release uses the old tile.
    assign wr_phys_s = RAW'(wr_ptr_r) * RAW'(DEPTH) + RAW'(bus.wr_addr);
    assign rd_phys_s = RAW'(rd_ptr_r) * RAW'(DEPTH) + RAW'(bus.rd_addr);

    assign len_over_s = (bus.wr_len > LW'(DEPTH));

    // Committed tile length, saturated to one bank.
    always_comb begin
        len_sat_s = bus.wr_len;
        if (len_over_s) begin
            len_sat_s = LW'(DEPTH);
        end else begin
            len_sat_s = bus.wr_len;
        end
    end

    // Full-bank count: a commit and a release together cancel out.
    always_comb begin
        level_nxt_s = level_r;
        case ({commit_acc_s, release_acc_s})
            2'b10:   level_nxt_s = level_r + LVW'(1);
            2'b01:   level_nxt_s = level_r - LVW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    assign err_set_s = (bus.wr_en      & ~(wr_ready_s & wr_addr_ok_s))
                     | (bus.wr_commit  & (~wr_ready_s | len_over_s))
                     | (bus.rd_en      & ~(rd_avail_s & rd_addr_ok_s))
                     | (bus.rd_release & ~rd_avail_s);

    // Ring bookkeeping: pointers, level, tile lengths, sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            level_r    <= {LVW{1'b0}};
            err_r      <= 1'b0;
            rd_valid_r <= 1'b0;
            for (int b = 0; b < NBANK; b++) begin
                len_r[b] <= {LW{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            level_r    <= {LVW{1'b0}};
            err_r      <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            if (commit_acc_s) begin
                len_r[wr_ptr_r] <= len_sat_s;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (release_acc_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            level_r    <= level_nxt_s;
            err_r      <= err_r | err_set_s;
            rd_valid_r <= rd_acc_s;
        end
    end

    irb_sdp_ram #(
        .DATA_W (DATA_W),
        .WORDS  (NBANK * DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_s),
        .waddr (wr_phys_s),
        .wdata (bus.wr_data),
        .re    (rd_acc_s),
        .raddr (rd_phys_s),
        .rdata (rd_data_s)
    );

    assign bus.wr_ready = wr_ready_s;
    assign bus.rd_avail = rd_avail_s;
    assign bus.rd_len   = rd_avail_s ? len_r[rd_ptr_r] : {LW{1'b0}};
    assign bus.level    = level_r;
    assign bus.err      = err_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_s;

endmodule
